wb_master_arbiter: RTL and testbench



---
 rtl/wb_arb_pkg.sv | 29 ++
 rtl/wb_arb_rr_picker.sv | 23 ++
 rtl/wb_master_arbiter.sv | 141 ++++++++++++++
 tb/tb_wb_master_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone master arbiter: FSM encoding, watchdog width
// and the round-robin selection function used by the picker.
package wb_arb_pkg;

  localparam int TIMEOUT_W   = 16;
  localparam int MAX_MASTERS = 8;
  localparam int PICK_PTR_W  = 3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  // Returns the first requester at or after ptr, wrapping at n; zero when nobody requests.
  function automatic logic [MAX_MASTERS-1:0] rr_pick(input logic [MAX_MASTERS-1:0] req,
                                                     input logic [PICK_PTR_W-1:0]  ptr,
                                                     input int                     n);
    logic [MAX_MASTERS-1:0] win;
    logic [3:0]             idx;
    win = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= 4'(n)) idx = idx - 4'(n);
      if ((i < n) && (win == '0) && req[idx[2:0]]) win[idx[2:0]] = 1'b1;
    end
    return win;
  endfunction

endpackage

// File: rtl/wb_arb_rr_picker.sv
// Combinational round-robin priority encoder: one-hot winner among NUM_MASTERS requests.
module wb_arb_rr_picker #(
  parameter int NUM_MASTERS = 2,
  parameter int PTR_W       = 1
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [PTR_W-1:0]       ptr,
  output logic [NUM_MASTERS-1:0] grant
);
  import wb_arb_pkg::*;

  logic [MAX_MASTERS-1:0] req_w;
  logic [PICK_PTR_W-1:0]  ptr_w;

  always_comb begin
    req_w                  = '0;
    req_w[NUM_MASTERS-1:0] = req;
    ptr_w                  = '0;
    ptr_w[PTR_W-1:0]       = ptr;
    grant                  = NUM_MASTERS'(rr_pick(req_w, ptr_w, NUM_MASTERS));
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave path between NUM_MASTERS masters.
// Optional stall watchdog is built when WB_ARB_TIMEOUT_EN is defined.
module wb_master_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              wb_clk_i,
  input  logic                              wb_rst_i,
  input  logic [NUM_MASTERS-1:0]            m_wb_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_wb_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_wb_we_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_wb_sel_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_wb_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wb_dat_i,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wb_dat_o,
  output logic [NUM_MASTERS-1:0]            m_wb_ack_o,
  output logic [NUM_MASTERS-1:0]            m_wb_err_o,
  output logic                              s_wb_cyc_o,
  output logic                              s_wb_stb_o,
  output logic                              s_wb_we_o,
  output logic [SEL_WIDTH-1:0]              s_wb_sel_o,
  output logic [ADDR_WIDTH-1:0]             s_wb_adr_o,
  output logic [DATA_WIDTH-1:0]             s_wb_dat_o,
  input  logic [DATA_WIDTH-1:0]             s_wb_dat_i,
  input  logic                              s_wb_ack_i,
  input  logic                              s_wb_err_i,
  output logic [NUM_MASTERS-1:0]            grant_o,
  output logic                              timeout_o
);

  localparam int PTR_W = $clog2(NUM_MASTERS);

  arb_state_t             state, state_nxt;
  logic [NUM_MASTERS-1:0] grant_q, grant_nxt, pick;
  logic [PTR_W-1:0]       ptr_q, ptr_nxt, gidx_q, gidx_nxt, pick_idx;
  logic                   busy, expire;

  wb_arb_rr_picker #(.NUM_MASTERS(NUM_MASTERS), .PTR_W(PTR_W)) u_picker (
    .req   (m_wb_cyc_i),
    .ptr   (ptr_q),
    .grant (pick)
  );

  always_comb begin
    pick_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++)
      if (pick[k]) pick_idx = PTR_W'(k);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      gidx_q  <= '0;
    end else begin
      state   <= state_nxt;
      grant_q <= grant_nxt;
      ptr_q   <= ptr_nxt;
      gidx_q  <= gidx_nxt;
    end
  end

  // Grant is held for the whole cyc tenure; dropping cyc forces one idle cycle.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant_q;
    ptr_nxt   = ptr_q;
    gidx_nxt  = gidx_q;
    case (state)
      ARB_IDLE: begin
        if (|m_wb_cyc_i) begin
          state_nxt = ARB_BUSY;
          grant_nxt = pick;
          gidx_nxt  = pick_idx;
        end
      end
      ARB_BUSY: begin
        if (!m_wb_cyc_i[gidx_q]) begin
          state_nxt = ARB_IDLE;
          grant_nxt = '0;
          ptr_nxt   = (gidx_q == PTR_W'(NUM_MASTERS - 1)) ? '0 : gidx_q + PTR_W'(1);
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  assign busy    = (state == ARB_BUSY);
  assign grant_o = grant_q;

  always_comb begin
    s_wb_cyc_o = 1'b0;
    s_wb_stb_o = 1'b0;
    s_wb_we_o  = 1'b0;
    s_wb_sel_o = '0;
    s_wb_adr_o = '0;
    s_wb_dat_o = '0;
    m_wb_ack_o = '0;
    m_wb_err_o = '0;
    m_wb_dat_o = '0;
    if (busy) begin
      s_wb_cyc_o = m_wb_cyc_i[gidx_q];
      s_wb_stb_o = m_wb_stb_i[gidx_q] & ~expire;
      s_wb_we_o  = m_wb_we_i[gidx_q];
      s_wb_sel_o = m_wb_sel_i[gidx_q*SEL_WIDTH +: SEL_WIDTH];
      s_wb_adr_o = m_wb_adr_i[gidx_q*ADDR_WIDTH +: ADDR_WIDTH];
      s_wb_dat_o = m_wb_dat_i[gidx_q*DATA_WIDTH +: DATA_WIDTH];
      m_wb_ack_o[gidx_q] = s_wb_ack_i;
      m_wb_err_o[gidx_q] = s_wb_err_i | expire;
      m_wb_dat_o[gidx_q*DATA_WIDTH +: DATA_WIDTH] = s_wb_dat_i;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 wd_run;

  // A response in the expiry cycle suppresses the timeout, so ack always wins.
  assign wd_run    = busy & m_wb_cyc_i[gidx_q] & m_wb_stb_i[gidx_q] & ~s_wb_ack_i & ~s_wb_err_i;
  assign expire    = wd_run & (wd_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
  assign timeout_o = expire;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)               wd_cnt <= '0;
    else if (!wd_run || expire) wd_cnt <= '0;
    else                        wd_cnt <= wd_cnt + TIMEOUT_W'(1);
  end
`else
  logic [TIMEOUT_W-1:0] unused_timeout;
  assign unused_timeout = TIMEOUT_W'(TIMEOUT_CYCLES);
  assign expire         = 1'b0;
  assign timeout_o      = 1'b0;
`endif

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed self-checking bench for wb_master_arbiter with three masters.
module tb_wb_master_arbiter;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_cyc, m_stb, m_we, m_ack, m_err, grant;
  logic [N*SW-1:0] m_sel;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat_w, m_dat_r;
  logic            s_cyc, s_stb, s_we, s_ack, s_err, timeout;
  logic [SW-1:0]   s_sel;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_w, s_dat_r;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  wb_master_arbiter #(
    .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_wb_cyc_i(m_cyc), .m_wb_stb_i(m_stb), .m_wb_we_i(m_we), .m_wb_sel_i(m_sel),
    .m_wb_adr_i(m_adr), .m_wb_dat_i(m_dat_w), .m_wb_dat_o(m_dat_r),
    .m_wb_ack_o(m_ack), .m_wb_err_o(m_err),
    .s_wb_cyc_o(s_cyc), .s_wb_stb_o(s_stb), .s_wb_we_o(s_we), .s_wb_sel_o(s_sel),
    .s_wb_adr_o(s_adr), .s_wb_dat_o(s_dat_w), .s_wb_dat_i(s_dat_r),
    .s_wb_ack_i(s_ack), .s_wb_err_i(s_err),
    .grant_o(grant), .timeout_o(timeout)
  );

  // ---------------- driver tasks ----------------
  task automatic drive_master(input logic [1:0] k, input logic cyc, input logic stb,
                              input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat);
    m_cyc[k] = cyc;
    m_stb[k] = stb;
    m_we[k]  = we;
    m_sel[k*SW +: SW] = 4'hF;
    m_adr[k*AW +: AW] = adr;
    m_dat_w[k*DW +: DW] = dat;
  endtask

  task automatic idle_all();
    m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat_w = '0;
    s_ack = 1'b0; s_err = 1'b0; s_dat_r = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_all();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    idle_all();
    drive_master(2'd0, 1'b1, 1'b1, 1'b1, 32'h1234_5678, 32'h8765_4321);
    s_ack = 1'b1; s_err = 1'b1; s_dat_r = 32'hFFFF_FFFF;
    #2;
    tests_run++; if (grant !== 3'b000) begin tests_failed++; $display("FAIL reset_grant: got %b expected 000", grant); end
    tests_run++; if ({s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_w} !== '0) begin tests_failed++; $display("FAIL reset_slave_out: got cyc=%b stb=%b adr=%h expected all 0", s_cyc, s_stb, s_adr); end
    tests_run++; if ({m_ack, m_err, m_dat_r} !== '0) begin tests_failed++; $display("FAIL reset_master_out: got ack=%b err=%b dat=%h expected all 0", m_ack, m_err, m_dat_r); end
    tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    apply_reset();
  endtask

  task automatic test_single_master();
    apply_reset();
    drive_master(2'd0, 1'b1, 1'b1, 1'b1, 32'h3000_0010, 32'hA5A5_A5A5);
    #1;
    tests_run++; if ({grant, s_cyc} !== 4'b000_0) begin tests_failed++; $display("FAIL single_idle: got grant=%b s_cyc=%b expected 000/0", grant, s_cyc); end
    step();
    tests_run++; if (grant !== 3'b001) begin tests_failed++; $display("FAIL single_grant: got %b expected 001", grant); end
    tests_run++; if ({s_cyc, s_stb, s_we} !== 3'b111) begin tests_failed++; $display("FAIL single_ctrl: got %b expected 111", {s_cyc, s_stb, s_we}); end
    tests_run++; if (s_adr !== 32'h3000_0010) begin tests_failed++; $display("FAIL single_adr: got %h expected 30000010", s_adr); end
    tests_run++; if (s_dat_w !== 32'hA5A5_A5A5) begin tests_failed++; $display("FAIL single_wdat: got %h expected a5a5a5a5", s_dat_w); end
    tests_run++; if (s_sel !== 4'hF) begin tests_failed++; $display("FAIL single_sel: got %h expected f", s_sel); end
    s_ack = 1'b1; s_dat_r = 32'hDEAD_BEEF;
    #1;
    tests_run++; if (m_ack !== 3'b001) begin tests_failed++; $display("FAIL single_ack: got %b expected 001", m_ack); end
    tests_run++; if (m_dat_r !== {64'h0, 32'hDEAD_BEEF}) begin tests_failed++; $display("FAIL single_rdat: got %h expected only slot0=deadbeef", m_dat_r); end
    s_err = 1'b1;
    #1;
    tests_run++; if ({m_ack, m_err} !== 6'b001_001) begin tests_failed++; $display("FAIL single_ack_err: got ack=%b err=%b expected 001/001", m_ack, m_err); end
    step();
    s_ack = 1'b0; s_err = 1'b0;
    drive_master(2'd0, 1'b0, 1'b0, 1'b0, '0, '0);
    #1;
    tests_run++; if ({grant, s_cyc, m_ack} !== 7'b001_0_000) begin tests_failed++; $display("FAIL single_release_pending: got grant=%b s_cyc=%b ack=%b expected 001/0/000", grant, s_cyc, m_ack); end
    step();
    tests_run++; if (grant !== 3'b000) begin tests_failed++; $display("FAIL single_released: got %b expected 000", grant); end
  endtask

  task automatic test_contention();
    apply_reset();
    drive_master(2'd0, 1'b1, 1'b1, 1'b0, 32'h100, '0);
    drive_master(2'd1, 1'b1, 1'b1, 1'b0, 32'h200, '0);
    step();
    tests_run++; if (grant !== 3'b001) begin tests_failed++; $display("FAIL cont_first: got %b expected 001", grant); end
    s_ack = 1'b1;
    #1;
    tests_run++; if (m_ack !== 3'b001) begin tests_failed++; $display("FAIL cont_ack_route: got %b expected 001", m_ack); end
    s_ack = 1'b0;
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    step();
    tests_run++; if ({grant, s_cyc} !== 4'b000_0) begin tests_failed++; $display("FAIL cont_idle_gap: got grant=%b s_cyc=%b expected 000/0", grant, s_cyc); end
    step();
    tests_run++; if (grant !== 3'b010) begin tests_failed++; $display("FAIL cont_second: got %b expected 010", grant); end
    tests_run++; if (s_adr !== 32'h200) begin tests_failed++; $display("FAIL cont_second_adr: got %h expected 200", s_adr); end
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    step();
    m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
    step();
    tests_run++; if (grant !== 3'b001) begin tests_failed++; $display("FAIL cont_wrap: got %b expected 001", grant); end
    idle_all();
    step();
  endtask

  task automatic test_rotation();
    logic [N-1:0] exp_tab[6];
    logic [1:0]   idx_tab[6];
    exp_tab = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    idx_tab = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    apply_reset();
    m_cyc = 3'b111; m_stb = 3'b111;
    for (int i = 0; i < 6; i++) begin
      step();
      tests_run++; if (grant !== exp_tab[i]) begin tests_failed++; $display("FAIL rot_grant[%0d]: got %b expected %b", i, grant, exp_tab[i]); end
      m_cyc[idx_tab[i]] = 1'b0;
      step();
      tests_run++; if (grant !== 3'b000) begin tests_failed++; $display("FAIL rot_gap[%0d]: got %b expected 000", i, grant); end
      m_cyc[idx_tab[i]] = 1'b1;
    end
    idle_all();
    step();
    step();
  endtask

  task automatic test_burst();
    apply_reset();
    drive_master(2'd1, 1'b1, 1'b1, 1'b0, 32'h40, '0);
    step();
    tests_run++; if (grant !== 3'b010) begin tests_failed++; $display("FAIL burst_grant: got %b expected 010", grant); end
    drive_master(2'd0, 1'b1, 1'b1, 1'b0, 32'h80, '0);
    for (int b = 0; b < 4; b++) begin
      s_ack = 1'b1;
      s_dat_r = DW'(b + 1);
      #1;
      tests_run++; if ({grant, m_ack} !== 6'b010_010) begin tests_failed++; $display("FAIL burst_beat[%0d]: got grant=%b ack=%b expected 010/010", b, grant, m_ack); end
      tests_run++; if (m_dat_r !== {32'h0, DW'(b + 1), 32'h0}) begin tests_failed++; $display("FAIL burst_data[%0d]: got %h expected slot1=%0d only", b, m_dat_r, b + 1); end
      step();
    end
    s_ack = 1'b0; s_dat_r = '0;
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    #1;
    tests_run++; if (grant !== 3'b010) begin tests_failed++; $display("FAIL burst_hold: got %b expected 010", grant); end
    step();
    tests_run++; if (grant !== 3'b000) begin tests_failed++; $display("FAIL burst_gap: got %b expected 000", grant); end
    step();
    tests_run++; if (grant !== 3'b001) begin tests_failed++; $display("FAIL burst_next: got %b expected 001", grant); end
    idle_all();
    step();
    step();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drive_master(2'd0, 1'b1, 1'b1, 1'b1, 32'h55, 32'h66);
    step();
    tests_run++; if (grant !== 3'b001) begin tests_failed++; $display("FAIL rmid_grant: got %b expected 001", grant); end
    s_ack = 1'b1; s_dat_r = 32'h77;
    #2 rst = 1'b1;
    #1;
    tests_run++; if ({grant, s_cyc, s_stb, s_we} !== 6'b000_000) begin tests_failed++; $display("FAIL rmid_async: got grant=%b cyc=%b stb=%b expected 000/0/0", grant, s_cyc, s_stb); end
    tests_run++; if ({m_ack, m_err, m_dat_r, s_adr} !== '0) begin tests_failed++; $display("FAIL rmid_abandon: got ack=%b dat=%h expected 0", m_ack, m_dat_r); end
    idle_all();
    step();
    rst = 1'b0;
    drive_master(2'd1, 1'b1, 1'b1, 1'b0, 32'h99, '0);
    step();
    tests_run++; if (grant !== 3'b010) begin tests_failed++; $display("FAIL rmid_regrant: got %b expected 010", grant); end
    idle_all();
    step();
    step();
  endtask

`ifdef WB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    apply_reset();
    drive_master(2'd0, 1'b1, 1'b1, 1'b0, 32'hA0, '0);
    step();
    for (int k = 1; k <= 8; k++) begin
      if (k < 8) begin
        tests_run++; if ({m_err, timeout, s_stb} !== 5'b000_0_1) begin tests_failed++; $display("FAIL wd_wait[%0d]: got err=%b to=%b stb=%b expected 000/0/1", k, m_err, timeout, s_stb); end
      end else begin
        tests_run++; if ({m_err, timeout, s_stb} !== 5'b001_1_0) begin tests_failed++; $display("FAIL wd_expire: got err=%b to=%b stb=%b expected 001/1/0", m_err, timeout, s_stb); end
      end
      step();
    end
    tests_run++; if ({m_err, timeout, s_stb} !== 5'b000_0_1) begin tests_failed++; $display("FAIL wd_restart: got err=%b to=%b stb=%b expected 000/0/1", m_err, timeout, s_stb); end
    idle_all();
    step();
    step();
  endtask

  task automatic test_timeout_ack();
    apply_reset();
    drive_master(2'd0, 1'b1, 1'b1, 1'b0, 32'hA0, '0);
    step();
    repeat (7) step();
    s_ack = 1'b1;
    #1;
    tests_run++; if ({m_ack, m_err, timeout} !== 7'b001_000_0) begin tests_failed++; $display("FAIL wd_ack_wins: got ack=%b err=%b to=%b expected 001/000/0", m_ack, m_err, timeout); end
    idle_all();
    step();
    step();
  endtask
`else
  task automatic test_no_watchdog();
    apply_reset();
    drive_master(2'd2, 1'b1, 1'b1, 1'b0, 32'hB0, '0);
    step();
    for (int k = 0; k < 12; k++) begin
      tests_run++; if ({m_err, timeout, s_stb} !== 5'b000_0_1) begin tests_failed++; $display("FAIL nowd_stall[%0d]: got err=%b to=%b stb=%b expected 000/0/1", k, m_err, timeout, s_stb); end
      step();
    end
    idle_all();
    step();
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL sim_time_limit: simulation did not finish within 200000 time units");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single_master();
    test_contention();
    test_rotation();
    test_burst();
    test_reset_mid();
`ifdef WB_ARB_TIMEOUT_EN
    test_timeout();
    test_timeout_ack();
`else
    test_no_watchdog();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
